// File: rtl/prienc_arbiter_4_pkg.sv
// Shared types and constants for the four-requester priority arbiter.
package prienc_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prienc_arbiter_4_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface prienc_arbiter_4_if;
  import prienc_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;
  logic             timeout;

  modport master (output req, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input req, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/prienc_arbiter_4_core.sv
// Combinational 4x2 priority encoder: MSB wins, valid when any bit is set.
module prienc_4x2_core
  import prienc_arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic [ID_W-1:0]  idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (vec[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/prienc_arbiter_4.sv
// Fixed-priority (3 highest) arbiter with grant hold, timeout mask and turnaround.
// Optional macro ROUND_ROBIN_EN rotates priority so the last winner becomes lowest.
module prienc_arbiter_4
  import prienc_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic              clk,
  input logic              rst,
  prienc_arbiter_4_if.slave bus
);

  localparam int unsigned CNT_W =
    ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1);

  state_t           state, state_nxt;
  logic [N_REQ-1:0] gnt_q, gnt_nxt, mask, mask_nxt;
  logic [N_REQ-1:0] req_c, eff, arb_vec, core_vec;
  logic [ID_W-1:0]  id_q, id_nxt, core_idx, win;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             timeout_q, timeout_nxt, core_valid, rel, expire;

`ifdef SYNTHESIS
  assign req_c = bus.req;
`else
  // Non-1 request bits (X/Z) count as idle so they never reach the state.
  always_comb begin
    req_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) req_c[i] = (bus.req[i] === 1'b1);
  end
`endif

  assign eff     = req_c & ~mask;
  assign arb_vec = (eff != '0) ? eff : req_c;

`ifdef ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr, ptr_nxt, src;

  // Rotate so bit 3 of the core input is requester ptr, then undo on the index.
  always_comb begin
    core_vec = '0;
    src      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      src         = ptr + ID_W'(k) + ID_W'(1);
      core_vec[k] = arb_vec[src];
    end
  end
  assign win     = core_idx + ptr + ID_W'(1);
  assign ptr_nxt = (rel || expire) ? id_q - ID_W'(1) : ptr;

  always_ff @(posedge clk) begin
    if (rst) ptr <= '1;
    else     ptr <= ptr_nxt;
  end
`else
  assign core_vec = arb_vec;
  assign win      = core_idx;
`endif

  prienc_4x2_core u_core (
    .vec   (core_vec),
    .idx   (core_idx),
    .valid (core_valid)
  );

  assign rel    = (state == GRANT) && !req_c[id_q];
  assign expire = (state == GRANT) && req_c[id_q] && (MAX_HOLD != 0) &&
                  (hold_cnt == CNT_W'(MAX_HOLD));

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt_q;
    id_nxt      = id_q;
    hold_nxt    = hold_cnt;
    mask_nxt    = mask;
    timeout_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (core_valid) begin
          state_nxt = GRANT;
          gnt_nxt   = onehot(win);
          id_nxt    = win;
          hold_nxt  = CNT_W'(1);
          mask_nxt  = '0;
        end
      end
      GRANT: begin
        if (rel || expire) begin
          state_nxt   = TURN;
          gnt_nxt     = '0;
          id_nxt      = '0;
          hold_nxt    = '0;
          timeout_nxt = expire;
          if (expire) mask_nxt = onehot(id_q);
        end else if ((MAX_HOLD != 0) && (hold_cnt != CNT_W'(MAX_HOLD))) begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_q     <= '0;
      id_q      <= '0;
      hold_cnt  <= '0;
      mask      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt_q     <= gnt_nxt;
      id_q      <= id_nxt;
      hold_cnt  <= hold_nxt;
      mask      <= mask_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_prienc_arbiter_4.sv
// Directed and randomized checks of prienc_arbiter_4 against an integer-level model.
module tb_prienc_arbiter_4;
  localparam int unsigned MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  prienc_arbiter_4_if bus ();

  prienc_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state: current owner (-1 none), cycles held, gap edges before
  // arbitration, masked requester (-1 none), priority top index, timeout flag.
  int m_owner = -1, m_held = 0, m_gap = 0, m_mask = -1, m_ptr = 3;
  bit m_to = 0;

  function automatic int pick(input logic [3:0] r, input int top);
    for (int s = 0; s < 4; s++) begin
      int i;
      i = (top - s + 4) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_drop();
`ifdef ROUND_ROBIN_EN
    m_ptr = (m_owner + 3) % 4;
`endif
    m_owner = -1;
    m_held  = 0;
    m_gap   = 1;
  endtask

  task automatic model_edge();
    logic [3:0] r, cand;
    int w;
    r    = bus.req;
    m_to = 0;
    if (rst) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_mask = -1; m_ptr = 3;
    end else if (m_owner >= 0) begin
      if (!r[m_owner]) model_drop();
      else if (MAX_HOLD > 0 && m_held == MAX_HOLD) begin
        m_to   = 1;
        m_mask = m_owner;
        model_drop();
      end else if (m_held < MAX_HOLD) m_held++;
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      cand = r;
      if (m_mask >= 0) cand[m_mask] = 1'b0;
      if (cand == 4'b0) cand = r;
      w = pick(cand, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_held = 1; m_mask = -1;
      end
    end
  endtask

  function automatic logic [7:0] obs();
    return {bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout};
  endfunction

  function automatic logic [7:0] model_out();
    logic [3:0] g;
    logic [1:0] id;
    g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    id = (m_owner >= 0) ? 2'(m_owner) : 2'b0;
    return {g, id, m_owner >= 0, m_to};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle();
    bus.req = 4'b0;
    repeat (4) cyc();
  endtask

  task automatic test_reset();
    logic [7:0] got;
    bus.req = 4'b1111;
    rst = 1'b1;
    repeat (2) begin
      cyc();
      got = obs();
      total++;
      if (got !== 8'b0000_00_0_0) $display("FAIL reset_hold got=%b want=%b", got, 8'b0);
      else passed++;
    end
    rst = 1'b0;
    cyc();
    got = obs();
    total++;
    if (got !== 8'b1000_11_1_0) $display("FAIL reset_first_grant got=%b want=%b", got, 8'b1000_11_1_0);
    else passed++;
  endtask

  task automatic test_priority();
    logic [7:0] got;
    settle();
    bus.req = 4'b0110;
    cyc();
    got = obs();
    total++;
    if (got !== 8'b0100_10_1_0) $display("FAIL priority_pick got=%b want=%b", got, 8'b0100_10_1_0);
    else passed++;
    bus.req = 4'b1110;
    repeat (3) begin
      cyc();
      got = obs();
      total++;
      if (got !== 8'b0100_10_1_0) $display("FAIL no_preempt got=%b want=%b", got, 8'b0100_10_1_0);
      else passed++;
    end
  endtask

  task automatic test_release_turnaround();
    logic [7:0] got, want;
    bus.req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      cyc();
      got  = obs();
      want = (i < 2) ? 8'b0000_00_0_0 : 8'b0010_01_1_0;
      total++;
      if (got !== want) $display("FAIL turnaround[%0d] got=%b want=%b", i, got, want);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp_q[$];
    logic [7:0] got;
    settle();
    repeat (MAX_HOLD) exp_q.push_back(8'b1000_11_1_0);
    exp_q.push_back(8'b0000_00_0_1);
    exp_q.push_back(8'b0000_00_0_0);
    repeat (MAX_HOLD) exp_q.push_back(8'b0001_00_1_0);
    exp_q.push_back(8'b0000_00_0_1);
    exp_q.push_back(8'b0000_00_0_0);
    exp_q.push_back(8'b1000_11_1_0);
    bus.req = 4'b1001;
    foreach (exp_q[i]) begin
      cyc();
      got = obs();
      total++;
      if (got !== exp_q[i]) $display("FAIL timeout_seq[%0d] got=%b want=%b", i, got, exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_sole_masked();
    logic [7:0] got, want;
    settle();
    bus.req = 4'b0100;
    for (int i = 0; i < MAX_HOLD + 3; i++) begin
      cyc();
      got = obs();
      if (i < MAX_HOLD) want = 8'b0100_10_1_0;
      else if (i == MAX_HOLD) want = 8'b0000_00_0_1;
      else if (i == MAX_HOLD + 1) want = 8'b0000_00_0_0;
      else want = 8'b0100_10_1_0;
      total++;
      if (got !== want) $display("FAIL sole_masked[%0d] got=%b want=%b", i, got, want);
      else passed++;
    end
  endtask

  task automatic test_order();
    int want_order[5];
    int got_id, waited;
`ifdef ROUND_ROBIN_EN
    want_order = '{3, 2, 1, 0, 3};
`else
    want_order = '{3, 3, 3, 3, 3};
`endif
    bus.req = 4'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      waited = 0;
      do begin
        cyc();
        waited++;
      end while (!bus.gnt_valid && waited < 10);
      got_id = bus.gnt_valid ? int'(bus.gnt_id) : -1;
      total++;
      if (got_id != want_order[n]) $display("FAIL grant_order[%0d] got=%0d want=%0d", n, got_id, want_order[n]);
      else passed++;
      if (got_id < 0) return;
      cyc();
      bus.req[got_id] = 1'b0;
      cyc();
      bus.req[got_id] = 1'b1;
    end
  endtask

  task automatic test_random();
    logic [7:0] got, want;
    logic [3:0] flip;
    settle();
    for (int i = 0; i < 600; i++) begin
      flip = '0;
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 7) == 0);
      bus.req = bus.req ^ flip;
      rst = ($urandom_range(0, 99) == 0);
      cyc();
      got  = obs();
      want = model_out();
      total++;
      if (got !== want) $display("FAIL random[%0d] req=%b got=%b want=%b", i, bus.req, got, want);
      else passed++;
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.req = 4'b1111;
    test_reset();
    test_priority();
    test_release_turnaround();
    test_timeout();
    test_sole_masked();
    test_order();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
